// File: rtl/hazard_pkg.sv
// Shared types and constants for the data-hazard / forwarding unit.
// Contents:
//   REG_ADDR_W          stored destination-register width (instances must
//                       use REGISTER_SIZE <= REG_ADDR_W)
//   FWD_REGFILE         forwarding select value meaning "read register file"
//   STAGE_EX/MEM/WB     scoreboard stage indices after decode
//   scoreboard_entry_t  one in-flight instruction record
package hazard_pkg;

  localparam int unsigned REG_ADDR_W  = 8;
  localparam int unsigned FWD_REGFILE = 0;

  localparam int unsigned STAGE_EX  = 1;
  localparam int unsigned STAGE_MEM = 2;
  localparam int unsigned STAGE_WB  = 3;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  is_load;
  } scoreboard_entry_t;

endpackage

// File: rtl/hazard_src_match.sv
// Per-source producer search over the hazard scoreboard.
// Ports:
//   sb_i         scoreboard, entry k = instruction in stage k (1 = EX)
//   rs_i         source register address of the decode instruction
//   rs_used_i    source is actually read
//   fwd_sel_o    0 = register file, k = forward from stage k
//   stall_req_o  youngest producer is a load whose data is not ready yet
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int unsigned REGISTER_SIZE    = 5,
  parameter int unsigned PIPE_DEPTH       = 3,
  parameter int unsigned LOAD_READY_STAGE = 2,
  parameter int unsigned SEL_W            = 2
) (
  input  scoreboard_entry_t [PIPE_DEPTH:1] sb_i,
  input  logic [REGISTER_SIZE-1:0]         rs_i,
  input  logic                             rs_used_i,
  output logic [SEL_W-1:0]                 fwd_sel_o,
  output logic                             stall_req_o
);

  logic [REG_ADDR_W-1:0] rs_ext;
  logic                  hit;
  logic                  hit_load;
  logic [SEL_W-1:0]      hit_k;

  assign rs_ext = REG_ADDR_W'(rs_i);

  // Ascending scan with a sticky hit flag: the youngest producer wins and
  // older writers of the same register are ignored.
  always_comb begin
    hit      = 1'b0;
    hit_load = 1'b0;
    hit_k    = '0;
    for (int unsigned k = STAGE_EX; k <= PIPE_DEPTH; k++) begin
      if (!hit && rs_used_i && (rs_ext != '0) &&
          sb_i[k].valid && sb_i[k].we && (sb_i[k].rd == rs_ext)) begin
        hit      = 1'b1;
        hit_k    = SEL_W'(k);
        hit_load = sb_i[k].is_load && (k < LOAD_READY_STAGE);
      end
    end
  end

  assign stall_req_o = hit && hit_load;
  assign fwd_sel_o   = (hit && !hit_load) ? hit_k : SEL_W'(FWD_REGFILE);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Data-hazard unit for the in-order pipeline: tracks in-flight destination
// registers, drives decode operand forwarding selects and stalls on
// load-use hazards.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   dec_valid/rd/rd_we/is_load   decode instruction description
//   dec_rs, dec_rs_used   decode source registers and their use flags
//   flush                 redirect; kills the decode instruction
//   f_to_d_enable_ff      fetch-to-decode flop enable
//   pc_enable             PC update enable
//   d_to_e_bubble         inject NOP into decode-to-execute flop
//   fwd_sel               per-source select, 0 = register file, k = stage k
//   stall_cycles          saturating stall-cycle counter
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REGISTER_SIZE    = 5,
  parameter int unsigned NUM_SRC          = 2,
  parameter int unsigned PIPE_DEPTH       = STAGE_WB,
  parameter int unsigned LOAD_READY_STAGE = STAGE_MEM,
  parameter int unsigned SEL_W            = $clog2(PIPE_DEPTH + 1),
  parameter int unsigned CNT_W            = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  dec_valid,
  input  logic [REGISTER_SIZE-1:0]              dec_rd,
  input  logic                                  dec_rd_we,
  input  logic                                  dec_is_load,
  input  logic [NUM_SRC-1:0][REGISTER_SIZE-1:0] dec_rs,
  input  logic [NUM_SRC-1:0]                    dec_rs_used,
  input  logic                                  flush,
  output logic                                  f_to_d_enable_ff,
  output logic                                  pc_enable,
  output logic                                  d_to_e_bubble,
  output logic [NUM_SRC-1:0][SEL_W-1:0]         fwd_sel,
  output logic [CNT_W-1:0]                      stall_cycles
);

  scoreboard_entry_t [PIPE_DEPTH:1] sb_q, sb_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;

  logic [NUM_SRC-1:0]            stall_req;
  logic [NUM_SRC-1:0][SEL_W-1:0] src_sel;
  logic                          stall;
  logic                          push;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_match #(
      .REGISTER_SIZE    (REGISTER_SIZE),
      .PIPE_DEPTH       (PIPE_DEPTH),
      .LOAD_READY_STAGE (LOAD_READY_STAGE),
      .SEL_W            (SEL_W)
    ) u_match (
      .sb_i        (sb_q),
      .rs_i        (dec_rs[i]),
      .rs_used_i   (dec_rs_used[i]),
      .fwd_sel_o   (src_sel[i]),
      .stall_req_o (stall_req[i])
    );
  end

  // One OR across sources, so two sources waiting on the same load still
  // produce a single stall cycle stream.
  assign stall = dec_valid && !flush && (|stall_req);
  assign push  = dec_valid && !stall && !flush;

  // A stalled or flushed decode slot enters EX as a bubble; the load keeps
  // advancing, so the hazard re-evaluates itself each cycle.
  always_comb begin
    sb_d = sb_q;
    for (int unsigned k = 2; k <= PIPE_DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    sb_d[STAGE_EX] = '0;
    if (push) begin
      sb_d[STAGE_EX].valid   = 1'b1;
      sb_d[STAGE_EX].rd      = REG_ADDR_W'(dec_rd);
      sb_d[STAGE_EX].we      = dec_rd_we;
      sb_d[STAGE_EX].is_load = dec_is_load;
    end
  end

  assign cnt_d = (stall && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    f_to_d_enable_ff = 1'b1;
    pc_enable        = 1'b1;
    d_to_e_bubble    = 1'b1;
    fwd_sel          = '0;
    if (rst) begin
      f_to_d_enable_ff = !stall;
      pc_enable        = !stall;
      d_to_e_bubble    = flush || stall;
      if (dec_valid && !flush && !stall) begin
        fwd_sel = src_sel;
      end
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench: two configurations driven by the same stimulus,
// each compared every cycle against a queue-based pipeline history model.
module tb_hazard_forward_ctrl;

  localparam int NS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst         = 1'b0;
  logic               dec_valid   = 1'b0;
  logic [4:0]         dec_rd      = '0;
  logic               dec_rd_we   = 1'b0;
  logic               dec_is_load = 1'b0;
  logic [1:0][4:0]    dec_rs      = '0;
  logic [1:0]         dec_rs_used = '0;
  logic               flush       = 1'b0;

  logic               f2d0, pc0, bub0;
  logic [1:0][1:0]    fwd0;
  logic [15:0]        cyc0;
  logic               f2d1, pc1, bub1;
  logic [1:0][2:0]    fwd1;
  logic [1:0]         cyc1;

  hazard_forward_ctrl #(
    .REGISTER_SIZE(5), .NUM_SRC(2), .PIPE_DEPTH(3), .LOAD_READY_STAGE(2), .CNT_W(16)
  ) u_dut0 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
    .dec_is_load(dec_is_load), .dec_rs(dec_rs), .dec_rs_used(dec_rs_used), .flush(flush),
    .f_to_d_enable_ff(f2d0), .pc_enable(pc0), .d_to_e_bubble(bub0), .fwd_sel(fwd0),
    .stall_cycles(cyc0)
  );

  hazard_forward_ctrl #(
    .REGISTER_SIZE(5), .NUM_SRC(2), .PIPE_DEPTH(4), .LOAD_READY_STAGE(3), .CNT_W(2)
  ) u_dut1 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
    .dec_is_load(dec_is_load), .dec_rs(dec_rs), .dec_rs_used(dec_rs_used), .flush(flush),
    .f_to_d_enable_ff(f2d1), .pc_enable(pc1), .d_to_e_bubble(bub1), .fwd_sel(fwd1),
    .stall_cycles(cyc1)
  );

  // History of instructions that entered EX, youngest first: element k-1 is
  // the instruction currently in stage k.
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } rec_t;

  rec_t hist [2][$];
  int   cnt  [2];
  int   dep  [2] = '{3, 4};
  int   lrs  [2] = '{2, 3};
  int   cmax [2] = '{65535, 3};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_reset(input int d);
    rec_t b;
    b = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
    hist[d].delete();
    for (int k = 0; k < dep[d]; k++) hist[d].push_back(b);
    cnt[d] = 0;
  endfunction

  function automatic void ref_eval(input int d, output bit stall, output int sel[NS]);
    stall = 1'b0;
    for (int i = 0; i < NS; i++) begin
      sel[i] = 0;
      if (dec_rs_used[i] && dec_rs[i] != 5'd0) begin
        for (int k = 1; k <= dep[d]; k++) begin
          rec_t e;
          e = hist[d][k-1];
          if (e.v && e.we && e.rd == int'(dec_rs[i])) begin
            if (e.ld && k < lrs[d]) stall = 1'b1;
            else                    sel[i] = k;
            break;
          end
        end
      end
    end
    stall = stall && rst && dec_valid && !flush;
  endfunction

  function automatic void ref_step(input int d, input bit stall);
    rec_t e;
    if (!rst) begin
      ref_reset(d);
    end else begin
      e.v  = dec_valid && !flush && !stall;
      e.rd = int'(dec_rd);
      e.we = dec_rd_we;
      e.ld = dec_is_load;
      hist[d].push_front(e);
      void'(hist[d].pop_back());
      if (stall && cnt[d] < cmax[d]) cnt[d]++;
    end
  endfunction

  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      bit st;
      int sel [NS];
      int ef, eb, gf, gp, gb, gc;
      int gw [NS];
      bit pass_fwd;
      ref_eval(d, st, sel);
      ef       = rst ? int'(!st) : 1;
      eb       = rst ? int'(flush || st) : 1;
      pass_fwd = rst && dec_valid && !flush && !st;
      if (d == 0) begin
        gf = int'(f2d0); gp = int'(pc0); gb = int'(bub0); gc = int'(cyc0);
        gw[0] = int'(fwd0[0]); gw[1] = int'(fwd0[1]);
      end else begin
        gf = int'(f2d1); gp = int'(pc1); gb = int'(bub1); gc = int'(cyc1);
        gw[0] = int'(fwd1[0]); gw[1] = int'(fwd1[1]);
      end
      check($sformatf("d%0d_f_to_d_enable", d), gf, ef);
      check($sformatf("d%0d_pc_enable", d), gp, ef);
      check($sformatf("d%0d_d_to_e_bubble", d), gb, eb);
      for (int i = 0; i < NS; i++)
        check($sformatf("d%0d_fwd_sel%0d", d, i), gw[i], pass_fwd ? sel[i] : 0);
      check($sformatf("d%0d_stall_cycles", d), gc, cnt[d]);
      ref_step(d, st);
    end
  endtask

  task automatic drive(input bit r, input bit v, input int rd, input bit we, input bit ld,
                       input int rs0, input int rs1, input bit [1:0] used, input bit fl);
    @(negedge clk);
    rst         = r;
    dec_valid   = v;
    dec_rd      = 5'(rd);
    dec_rd_we   = we;
    dec_is_load = ld;
    dec_rs[0]   = 5'(rs0);
    dec_rs[1]   = 5'(rs1);
    dec_rs_used = used;
    flush       = fl;
    #1;
    check_cycle();
  endtask

  initial begin
    ref_reset(0);
    ref_reset(1);

    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    drive(0, 1, 4, 1, 1, 4, 4, 2'b11, 0);

    // ALU back-to-back, then the same dependency from MEM
    drive(1, 1, 5, 1, 0, 0, 0, 2'b00, 0);
    drive(1, 1, 6, 1, 0, 5, 0, 2'b01, 0);
    drive(1, 1, 0, 0, 0, 5, 0, 2'b01, 0);

    // Load-use on source 1, held until each configuration releases it
    drive(1, 1, 7, 1, 1, 0, 0, 2'b00, 0);
    repeat (4) drive(1, 1, 8, 1, 0, 0, 7, 2'b10, 0);

    // Both sources on the same load
    drive(1, 1, 9, 1, 1, 0, 0, 2'b00, 0);
    repeat (3) drive(1, 1, 10, 1, 0, 9, 9, 2'b11, 0);

    // Flush while a load-use hazard is present
    drive(1, 1, 11, 1, 1, 0, 0, 2'b00, 0);
    drive(1, 1, 12, 1, 0, 11, 0, 2'b01, 1);
    drive(1, 1, 13, 1, 0, 11, 0, 2'b01, 0);

    // Youngest producer wins; x0 never matches
    drive(1, 1, 3, 1, 0, 0, 0, 2'b00, 0);
    drive(1, 1, 3, 1, 0, 0, 0, 2'b00, 0);
    drive(1, 1, 0, 1, 0, 3, 0, 2'b01, 0);
    drive(1, 1, 14, 1, 0, 0, 0, 2'b01, 0);

    // Decode not valid with a live hazard
    drive(1, 1, 15, 1, 1, 0, 0, 2'b00, 0);
    drive(1, 0, 0, 0, 0, 15, 15, 2'b11, 0);

    // Repeated load-use to saturate the narrow counter
    repeat (3) begin
      drive(1, 1, 7, 1, 1, 0, 0, 2'b00, 0);
      repeat (3) drive(1, 1, 8, 1, 0, 7, 0, 2'b01, 0);
    end

    // Reset asserted in the middle of a stall
    drive(1, 1, 7, 1, 1, 0, 0, 2'b00, 0);
    drive(1, 1, 8, 1, 0, 7, 0, 2'b01, 0);
    drive(0, 1, 8, 1, 0, 7, 0, 2'b01, 0);
    drive(1, 1, 8, 1, 0, 7, 0, 2'b01, 0);

    // Randomized traffic with a small register pool to force hazards
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 49) != 0,
            $urandom_range(0, 9) < 8,
            int'($urandom_range(0, 3)),
            $urandom_range(0, 4) != 0,
            $urandom_range(0, 4) < 2,
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Parametrised data-hazard unit for the in-order RISC-V pipeline. It tracks the destination registers of in-flight instructions in a scoreboard shift register, one entry per post-decode stage. It produces per-source forwarding selects for the decode-stage operand muxes. It stalls fetch/decode and injects a bubble whenever a load result is not yet available.

Parameters:
REGISTER_SIZE, 5, register address width
NUM_SRC, 2, number of source operands checked per instruction
PIPE_DEPTH, 3, tracked stages after decode (1=EX, 2=MEM, 3=WB)
LOAD_READY_STAGE, 2, first stage index at which load data can be forwarded (2..PIPE_DEPTH)
SEL_W, $clog2(PIPE_DEPTH+1), forwarding select width
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset
dec_valid  input  1  decode holds a real instruction
dec_rd  input  REGISTER_SIZE  decode destination register
dec_rd_we  input  1  decode instruction writes dec_rd
dec_is_load  input  1  decode instruction is a load
dec_rs  input  [NUM_SRC][REGISTER_SIZE]  decode source registers
dec_rs_used  input  [NUM_SRC]  source i is actually read
flush  input  1  branch/jump redirect; kill the decode instruction
f_to_d_enable_ff  output  1  fetch-to-decode flop enable
pc_enable  output  1  PC update enable
d_to_e_bubble  output  1  load a NOP into decode-to-execute flop
fwd_sel  output  [NUM_SRC][SEL_W]  0 = register file, k = stage k result
stall_cycles  output  CNT_W  saturating count of stall cycles

Behaviour:
- Scoreboard entry k (1..PIPE_DEPTH) holds {valid, rd, we, is_load} for the instruction in stage k.
- Each cycle: entry[k+1] <= entry[k].
- entry[1] <= the decode instruction when dec_valid && !stall && !flush; otherwise a bubble (valid=0).
- Entry PIPE_DEPTH is discarded.
- A producer k matches source i when all hold:
  - dec_rs_used[i]
  - entry[k].valid && entry[k].we
  - entry[k].rd == dec_rs[i]
  - dec_rs[i] != 0 (x0 never matches)
- Priority: lowest matching k (youngest producer) wins. Older matches are ignored.
- Winning producer is a load with k < LOAD_READY_STAGE: stall_req for source i.
- Otherwise fwd_sel[i] = k; fwd_sel[i] = 0 if there is no match.
- stall = dec_valid && !flush && (OR of stall_req over all i).
- When stall: f_to_d_enable_ff=0, pc_enable=0, d_to_e_bubble=1, all fwd_sel=0.
- flush has priority over stall:
  - f_to_d_enable_ff=1, pc_enable=1, d_to_e_bubble=1, fwd_sel=0.
  - The entry is not pushed.
- Stall duration: a load immediately followed by a dependent instruction stalls exactly LOAD_READY_STAGE-1 cycles. The bubble advances through the scoreboard, so re-evaluation happens naturally.
- Two sources stalling on the same load give a single stall, not a doubled one.
- dec_valid=0 gives no stall and fwd_sel=0.
- Latency: all outputs are combinational from the dec_* inputs and the registered scoreboard, with no added cycles.
- stall_cycles increments on every stall cycle and saturates at all-ones.
- Reset (rst==0 sampled at posedge):
  - All entries invalid; stall_cycles=0.
  - While rst==0, outputs are forced to f_to_d_enable_ff=1, pc_enable=1, d_to_e_bubble=1, fwd_sel=0.
- Reset asserted mid-stall clears the stall on the next edge.
- No multiple drivers; fwd_sel default is assigned before the per-source loop.

Decomposition:
- Shared package hazard_pkg:
  - scoreboard_entry_t struct
  - FWD_REGFILE=0 constant
  - stage index constants STAGE_EX=1, STAGE_MEM=2, STAGE_WB=3
- Natural sub-module: hazard_src_match (one per source, generate loop). It takes the scoreboard and one source, and returns {fwd_sel, stall_req} via a priority encode.
- Scoreboard shift register and counter stay in the top.

Test Plan:
- ALU back-to-back: EX entry rd=5 we; decode rs0=5 -> fwd_sel[0]=1, no stall. Next cycle same dependency at MEM -> fwd_sel[0]=2.
- Load-use: load rd=7, then decode rs1=7 -> stall one cycle (f_to_d_enable_ff=0, d_to_e_bubble=1). Next cycle fwd_sel[1]=2, stall_cycles=1.
- Priority: EX rd=3 and MEM rd=3 both valid, decode rs0=3 -> fwd_sel[0]=1. x0 case: EX rd=0, rs0=0 -> fwd_sel[0]=0.
- Flush during load-use condition -> no stall, d_to_e_bubble=1, entry[1] invalid next cycle, stall_cycles unchanged.
- LOAD_READY_STAGE=3, PIPE_DEPTH=4 variant: load then dependent -> exactly 2 stall cycles, then fwd_sel=3. Also check saturation with CNT_W=2: 5 stalls -> stall_cycles=3.
- Assert rst=0 during a stall -> next edge all entries invalid, f_to_d_enable_ff=1, fwd_sel=0, stall_cycles=0.
